// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM state type and constant helpers for the arithmetic library
package arith_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fs_wbit.sv
// fs_wbit: combinational W-bit ripple-borrow subtractor built from full-subtractor cells
module fs_wbit #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         b_in,
  output logic [W-1:0] d,
  output logic         b_out
);
  logic br;
  // borrow ripples from bit 0 upward through each full-subtractor cell
  always_comb begin
    d = '0;
    br = b_in;
    for (int i = 0; i < W; i++) begin
      d[i] = x[i] ^ y[i] ^ br;
      br = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    b_out = br;
  end
endmodule

// File: rtl/seq_subtractor.sv
// seq_subtractor: digit-serial x - y - b_in, W bits per clock through a narrow borrow slice
module seq_subtractor
  import arith_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         b_out,
  output logic         ovf
);
  localparam int D  = N / W;
  localparam int CW = clog2(D);
  if (N % W != 0) begin : g_bad_width
    $error("seq_subtractor: N must be a multiple of W");
  end
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   xs_q, xs_d, ys_q, ys_d, d_q, d_d;
  logic           br_q, br_d, xsgn_q, xsgn_d, ysgn_q, ysgn_d;
  logic           done_q, done_d, bo_q, bo_d, ovf_q, ovf_d;
  logic [W-1:0]   dig;
  logic           bw;
  fs_wbit #(.W(W)) u_fs (
    .x    (xs_q[W-1:0]),
    .y    (ys_q[W-1:0]),
    .b_in (br_q),
    .d    (dig),
    .b_out(bw)
  );
  // accept a start in IDLE, then consume one digit per cycle; flags settle on the final digit
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    xs_d = xs_q;
    ys_d = ys_q;
    d_d = d_q;
    br_d = br_q;
    xsgn_d = xsgn_q;
    ysgn_d = ysgn_q;
    bo_d = bo_q;
    ovf_d = ovf_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        cnt_d = '0;
        xs_d = x;
        ys_d = y;
        br_d = b_in;
        xsgn_d = x[N-1];
        ysgn_d = y[N-1];
      end
    end else begin
      xs_d = xs_q >> W;
      ys_d = ys_q >> W;
      d_d = (d_q >> W) | (N'(dig) << (N - W));
      br_d = bw;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(D - 1)) begin
        state_d = IDLE;
        done_d = 1'b1;
        bo_d = bw;
        ovf_d = (xsgn_q != ysgn_q) && (dig[W-1] != xsgn_q);
      end
    end
  end
  // state and datapath registers; reset aborts any run without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      xs_q <= '0;
      ys_q <= '0;
      d_q <= '0;
      br_q <= 1'b0;
      xsgn_q <= 1'b0;
      ysgn_q <= 1'b0;
      done_q <= 1'b0;
      bo_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      xs_q <= xs_d;
      ys_q <= ys_d;
      d_q <= d_d;
      br_q <= br_d;
      xsgn_q <= xsgn_d;
      ysgn_q <= ysgn_d;
      done_q <= done_d;
      bo_q <= bo_d;
      ovf_q <= ovf_d;
    end
  end
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign d = d_q;
  assign b_out = bo_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_seq_subtractor.sv
// tb_seq_subtractor: directed and random checks of three widths against an arithmetic model
module tb_seq_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] x = '0, y = '0;
  logic b_in = 1'b0;
  logic start4 = 1'b0, start1 = 1'b0, start32 = 1'b0;
  logic busy4, done4, bo4, ov4;
  logic busy1, done1, bo1, ov1;
  logic busy32, done32, bo32, ov32;
  logic [31:0] d4, d1, d32;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_subtractor #(.N(32), .W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .x(x), .y(y), .b_in(b_in),
    .busy(busy4), .done(done4), .d(d4), .b_out(bo4), .ovf(ov4));
  seq_subtractor #(.N(32), .W(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .x(x), .y(y), .b_in(b_in),
    .busy(busy1), .done(done1), .d(d1), .b_out(bo1), .ovf(ov1));
  seq_subtractor #(.N(32), .W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .x(x), .y(y), .b_in(b_in),
    .busy(busy32), .done(done32), .d(d32), .b_out(bo32), .ovf(ov32));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ovf, borrow, difference} from plain integer arithmetic
  function automatic logic [33:0] ref_sub(input logic [31:0] a, input logic [31:0] b, input logic bi);
    longint ur, sr;
    logic [63:0] u;
    logic bor, ov;
    ur = longint'({32'b0, a}) - longint'({32'b0, b}) - longint'(bi);
    sr = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    u = ur;
    bor = ur < 0;
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {ov, bor, u[31:0]};
  endfunction

  // run one operation on all three widths; check results, latency and single done pulse
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bi, input string tag);
    logic [33:0] e, r4, r1, r32;
    int l4, l1, l32, n4, n1, n32;
    e = ref_sub(a, b, bi);
    l4 = 0; l1 = 0; l32 = 0; n4 = 0; n1 = 0; n32 = 0;
    r4 = '0; r1 = '0; r32 = '0;
    @(negedge clk);
    x = a; y = b; b_in = bi;
    start4 = 1'b1; start1 = 1'b1; start32 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start1 = 1'b0; start32 = 1'b0;
    x = $urandom; y = $urandom; b_in = 1'($urandom);
    chk({tag, "_busy"}, 64'({busy4, busy1, busy32}), 64'(3'b111));
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (done4) begin n4++; if (l4 == 0) begin l4 = k; r4 = {ov4, bo4, d4}; end end
      if (done1) begin n1++; if (l1 == 0) begin l1 = k; r1 = {ov1, bo1, d1}; end end
      if (done32) begin n32++; if (l32 == 0) begin l32 = k; r32 = {ov32, bo32, d32}; end end
    end
    chk({tag, "_w4_res"}, 64'(r4), 64'(e));
    chk({tag, "_w1_res"}, 64'(r1), 64'(e));
    chk({tag, "_w32_res"}, 64'(r32), 64'(e));
    chk({tag, "_lat"}, 64'({l4[7:0], l1[7:0], l32[7:0]}), 64'({8'd8, 8'd32, 8'd1}));
    chk({tag, "_npulse"}, 64'({n4[7:0], n1[7:0], n32[7:0]}), 64'({8'd1, 8'd1, 8'd1}));
    chk({tag, "_hold"}, 64'({ov4, bo4, d4}), 64'(e));
  endtask

  initial begin
    logic [33:0] e;
    int bc, nd;
    #1;
    chk("reset_async", 64'({busy4, done4, bo4, ov4, d4}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_idle", 64'({busy4, done4, bo4, ov4, d4, busy1, done1, busy32, done32}), 64'(0));
    do_op(32'h0000_0005, 32'h0000_0003, 1'b0, "small");
    do_op(32'h0000_0000, 32'h0000_0001, 1'b0, "ripple");
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0, "negovf");
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, "posovf");
    do_op(32'h0000_0000, 32'h0000_0000, 1'b1, "binonly");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "allone");
    // a second start mid-run must be ignored
    e = ref_sub(32'h1234_5678, 32'h0101_0101, 1'b1);
    @(negedge clk);
    x = 32'h1234_5678; y = 32'h0101_0101; b_in = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    bc = busy4 ? 1 : 0;
    nd = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (busy4) bc++;
      if (done4) begin
        nd++;
        chk("ignore_res", 64'({ov4, bo4, d4}), 64'(e));
        chk("ignore_lat", 64'(k), 64'(8));
      end
      if (k == 3) begin x = 32'hDEAD_BEEF; y = 32'h0BAD_F00D; b_in = 1'b0; start4 = 1'b1; end
      else start4 = 1'b0;
    end
    chk("ignore_busycnt", 64'(bc), 64'(8));
    chk("ignore_ndone", 64'(nd), 64'(1));
    // reset mid-run aborts and clears flags left by a prior overflow result
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, "preabort");
    @(negedge clk);
    x = 32'hFFFF_0000; y = 32'h0000_FFFF; b_in = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_clear", 64'({busy4, done4, bo4, ov4, d4}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done4 || busy4) nd++;
    end
    chk("abort_nodone", 64'(nd), 64'(0));
    do_op(32'h0000_0010, 32'h0000_0020, 1'b0, "postabort");
    // start held high across done: next operation accepted immediately
    @(negedge clk);
    x = 32'h0000_0005; y = 32'h0000_0003; b_in = 1'b0; start4 = 1'b1;
    @(negedge clk);
    x = 32'h0000_0100; y = 32'h0000_0001; b_in = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 8) chk("b2b_first", 64'({done4, busy4, d4}), 64'({1'b1, 1'b0, 32'h2}));
      if (k == 9) begin
        chk("b2b_rebusy", 64'({done4, busy4}), 64'({1'b0, 1'b1}));
        start4 = 1'b0;
      end
      if (k == 17) chk("b2b_second", 64'({done4, bo4, ov4, d4}), 64'({1'b1, 1'b0, 1'b0, 32'hFE}));
    end
    for (int n = 0; n < 800; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case (n % 4)
        0: ra = ra & 32'h0000_00FF;
        1: rb = ~ra;
        2: rb = ra;
        default: ;
      endcase
      do_op(ra, rb, 1'(n % 2), $sformatf("rnd%0d", n));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
